quiz_round_controller: RTL
==========================

Name: quiz_round_controller

Overview:
- Sequences one mental-math game over NUM_ROUNDS questions.
- Enables the 4-bit free-running RNG counter and samples its count value to build two operands per question.
- Presents each question and times the player's answer.
- Judges the answer, keeps the score, and signals game completion to the display/UI logic.

Parameters:
NUM_ROUNDS, 8, questions per game (1..15)
TIMEOUT_CYCLES, 1000, answer window in clk cycles per question (2..65535)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
start  input  1  level; begins a game when sampled high in IDLE or DONE
abort  input  1  level; returns to IDLE from any state
op_sel  input  1  0 = addition, 1 = multiplication; sampled in GEN
rng_value  input  4  count value from RNG counter
answer  input  8  player answer, unsigned
answer_valid  input  1  one-cycle strobe qualifying answer
begin_count  output  1  enable to RNG counter
operand_a  output  4  current first operand
operand_b  output  4  current second operand
op_latched  output  1  operation of current question
question_valid  output  1  high while awaiting answer
correct  output  1  one-cycle pulse, answer matched
wrong  output  1  one-cycle pulse, answer mismatched
timeout  output  1  one-cycle pulse, window expired
score  output  4  correct answers this game
round  output  4  questions completed this game
busy  output  1  high in GEN/ASK/RESULT
done  output  1  high in DONE

Behaviour:
- reset low (async): state IDLE; all outputs 0 except begin_count=1; lfsr=8'hA5; timer=0; expected=0.
- All outputs registered; updates on rising clk only.
- LFSR (8-bit, Fibonacci):
  - next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances every cycle in every state.
- begin_count: 1 in all states except DONE.
- IDLE:
  - start=1 -> GEN; score<=0, round<=0.
- GEN (exactly 1 cycle):
  - operand_a<=rng_value; operand_b<=rng_value^lfsr[3:0] (current lfsr value); op_latched<=op_sel.
  - expected<= a+b (zero-extended) or a*b (8-bit, max 225), computed from the same captured values.
  - timer<=0 -> ASK.
- ASK:
  - question_valid=1 (first high the cycle after GEN); timer increments each cycle.
  - answer_valid=1 -> RESULT; correct if answer==expected, else wrong.
  - answer_valid=0 and timer==TIMEOUT_CYCLES-1 -> RESULT with timeout.
  - answer_valid and timer expiry in the same cycle: the answer is judged; no timeout.
  - answer_valid outside ASK is ignored.
- RESULT (exactly 1 cycle):
  - question_valid=0; exactly one of correct/wrong/timeout is high.
  - score+1 if correct; round+1.
  - Incremented round==NUM_ROUNDS -> DONE, else GEN.
- DONE:
  - done=1; score, round and operands held.
  - start=1 -> GEN; score<=0, round<=0, done<=0.
- start is ignored in GEN/ASK/RESULT.
- abort=1 in any state -> IDLE next cycle.
  - Clears question_valid, busy, done and the pulses.
  - Holds score/round.
  - abort has priority over start and answer_valid.
- Async reset mid-game: immediate return to reset values; no result pulse.
- score never exceeds NUM_ROUNDS; no wrap is possible.

Test Plan:
- Addition, correct answer: reset, hold rng_value=5, op_sel=0, start 1 cycle. Read operands after GEN; strobe answer=a+b 3 cycles later -> correct pulse 1 cycle, score=1, round=1, then GEN again.
- Multiply extremes: force operand capture with rng_value=15 and lfsr[3:0]=0 (operands 15,15), op_sel=1, answer=225 -> correct. Same setup, answer=224 -> wrong, score unchanged.
- Timeout, TIMEOUT_CYCLES=16: no answer -> timeout pulse in the cycle after the 16th question_valid cycle; score unchanged, round+1. Separately, answer_valid exactly on cycle 16 -> correct/wrong, no timeout.
- Full game, NUM_ROUNDS=4: answers correct, correct, wrong, correct -> done=1, score=3, round=4, begin_count=0. start in DONE -> score=0, busy=1.
- Interrupts: abort during ASK -> IDLE next cycle, question_valid=0, no pulse. Reset low asynchronously mid-ASK -> outputs 0 without a clk edge, begin_count=1, lfsr=8'hA5.

Source files
------------

// File: rtl/quiz_round_controller.sv
// quiz_round_controller
// Sequences one mental-math game of NUM_ROUNDS questions. Each question takes
// two operands from the free-running RNG counter and an internal LFSR. It then
// times the player's answer, judges it, and keeps score.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          level, begins a game from IDLE or DONE
//   abort          level, returns to IDLE from any state (highest priority)
//   op_sel         0 = add, 1 = multiply, sampled in GEN
//   rng_value[3:0] count value from the RNG counter
//   answer[7:0]    player answer, qualified by answer_valid
//   answer_valid   one-cycle strobe, only honoured in ASK
//   begin_count    RNG counter enable, low only in DONE
//   operand_a/b    operands of the current question
//   op_latched     operation of the current question
//   question_valid high while an answer is awaited
//   correct/wrong/timeout  one-cycle verdict pulses, asserted during RESULT
//   score, round   correct answers / questions completed this game
//   busy, done     game in progress / game finished
//
// All outputs are registered. The comb block computes the value each
// register takes on the next clock edge.
module quiz_round_controller #(
   parameter int NUM_ROUNDS     = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       op_sel,
   input  logic [3:0] rng_value,
   input  logic [7:0] answer,
   input  logic       answer_valid,
   output logic       begin_count,
   output logic [3:0] operand_a,
   output logic [3:0] operand_b,
   output logic       op_latched,
   output logic       question_valid,
   output logic       correct,
   output logic       wrong,
   output logic       timeout,
   output logic [3:0] score,
   output logic [3:0] round,
   output logic       busy,
   output logic       done
);

   // state  | meaning
   // -------+-----------------------------------------------
   // IDLE   | no game; waits for start
   // GEN    | one cycle: capture operands and expected result
   // ASK    | question shown; answer window timer running
   // RESULT | one cycle: verdict pulse; score and round already updated
   // DONE   | game over; results held until start
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GEN    = 3'd1,
      S_ASK    = 3'd2,
      S_RESULT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  ROUND_LAST = 4'(NUM_ROUNDS);

   state_t      state, state_nxt;
   logic [7:0]  lfsr, lfsr_nxt;
   logic [15:0] timer, timer_nxt;
   logic [7:0]  expected, expected_nxt;
   logic [3:0]  cap_b;
   logic [3:0]  operand_a_nxt, operand_b_nxt, score_nxt, round_nxt;
   logic        op_latched_nxt, correct_nxt, wrong_nxt, timeout_nxt;
   logic        question_valid_nxt, busy_nxt, done_nxt, begin_count_nxt;

   always_comb begin
      state_nxt      = state;
      lfsr_nxt       = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      timer_nxt      = timer;
      expected_nxt   = expected;
      operand_a_nxt  = operand_a;
      operand_b_nxt  = operand_b;
      op_latched_nxt = op_latched;
      score_nxt      = score;
      round_nxt      = round;
      correct_nxt    = 1'b0;
      wrong_nxt      = 1'b0;
      timeout_nxt    = 1'b0;
      cap_b          = rng_value ^ lfsr[3:0];

      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_nxt = S_GEN;
                  score_nxt = '0;
                  round_nxt = '0;
               end
            end
            S_GEN: begin
               operand_a_nxt  = rng_value;
               operand_b_nxt  = cap_b;
               op_latched_nxt = op_sel;
               // Zero-extend before the operation so 15*15 keeps all 8 bits.
               expected_nxt   = op_sel ? ({4'b0, rng_value} * {4'b0, cap_b})
                                       : ({4'b0, rng_value} + {4'b0, cap_b});
               timer_nxt      = '0;
               state_nxt      = S_ASK;
            end
            S_ASK: begin
               timer_nxt = timer + 16'd1;
               // An answer in the final window cycle still counts.
               if (answer_valid) begin
                  state_nxt = S_RESULT;
                  round_nxt = round + 4'd1;
                  if (answer == expected) begin
                     correct_nxt = 1'b1;
                     score_nxt   = score + 4'd1;
                  end else begin
                     wrong_nxt = 1'b1;
                  end
               end else if (timer == TIMER_LAST) begin
                  state_nxt   = S_RESULT;
                  round_nxt   = round + 4'd1;
                  timeout_nxt = 1'b1;
               end
            end
            S_RESULT: begin
               state_nxt = (round == ROUND_LAST) ? S_DONE : S_GEN;
            end
            S_DONE: begin
               if (start) begin
                  state_nxt = S_GEN;
                  score_nxt = '0;
                  round_nxt = '0;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      question_valid_nxt = (state_nxt == S_ASK);
      busy_nxt           = (state_nxt == S_GEN) || (state_nxt == S_ASK) ||
                           (state_nxt == S_RESULT);
      done_nxt           = (state_nxt == S_DONE);
      begin_count_nxt    = (state_nxt != S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         lfsr           <= 8'hA5;
         timer          <= '0;
         expected       <= '0;
         operand_a      <= '0;
         operand_b      <= '0;
         op_latched     <= 1'b0;
         score          <= '0;
         round          <= '0;
         correct        <= 1'b0;
         wrong          <= 1'b0;
         timeout        <= 1'b0;
         question_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         begin_count    <= 1'b1;
      end else begin
         state          <= state_nxt;
         lfsr           <= lfsr_nxt;
         timer          <= timer_nxt;
         expected       <= expected_nxt;
         operand_a      <= operand_a_nxt;
         operand_b      <= operand_b_nxt;
         op_latched     <= op_latched_nxt;
         score          <= score_nxt;
         round          <= round_nxt;
         correct        <= correct_nxt;
         wrong          <= wrong_nxt;
         timeout        <= timeout_nxt;
         question_valid <= question_valid_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         begin_count    <= begin_count_nxt;
      end
   end

endmodule
